// File: rtl/adder.sv
// Full adder with a registered observation stage: captures qualified samples,
// keeps a saturating running sum of {carry_out, result} and a wrapping sample count.
module adder #(
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             in_valid,
    output logic             result,
    output logic             carry_out,
    output logic             q_result,
    output logic             q_carry,
    output logic             q_valid,
    output logic [ACC_W-1:0] acc,
    output logic             acc_sat,
    output logic [ACC_W-1:0] sample_cnt
);

    logic             q_result_q, q_result_d;
    logic             q_carry_q,  q_carry_d;
    logic             q_valid_q,  q_valid_d;
    logic [ACC_W-1:0] acc_q,      acc_d;
    logic             acc_sat_q,  acc_sat_d;
    logic [ACC_W-1:0] cnt_q,      cnt_d;
    logic [ACC_W:0]   acc_sum;

    assign result    = a ^ b ^ c;
    assign carry_out = (a & b) | (a & c) | (b & c);

    // One spare bit catches overflow past 2^ACC_W-1.
    assign acc_sum = {1'b0, acc_q} + {{(ACC_W-1){1'b0}}, carry_out, result};

    always_comb begin
        q_result_d = q_result_q;
        q_carry_d  = q_carry_q;
        q_valid_d  = 1'b0;
        acc_d      = acc_q;
        acc_sat_d  = acc_sat_q;
        cnt_d      = cnt_q;
        if (in_valid) begin
            q_result_d = result;
            q_carry_d  = carry_out;
            q_valid_d  = 1'b1;
            cnt_d      = cnt_q + 1'b1;
            if (acc_sum[ACC_W]) begin
                acc_d     = '1;
                acc_sat_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_result_q <= 1'b0;
            q_carry_q  <= 1'b0;
            q_valid_q  <= 1'b0;
            acc_q      <= '0;
            acc_sat_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            q_result_q <= q_result_d;
            q_carry_q  <= q_carry_d;
            q_valid_q  <= q_valid_d;
            acc_q      <= acc_d;
            acc_sat_q  <= acc_sat_d;
            cnt_q      <= cnt_d;
        end
    end

    assign q_result   = q_result_q;
    assign q_carry    = q_carry_q;
    assign q_valid    = q_valid_q;
    assign acc        = acc_q;
    assign acc_sat    = acc_sat_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_adder.sv
// Bench for adder: three instances (ACC_W = 8, 4, 2) share stimulus; a scoreboard
// queue holds expected registered sums, and a small model tracks acc/sat/count.
module tb_adder;

    typedef struct {
        logic r;
        logic c;
    } exp_t;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0, in_valid = 1'b0;

    logic       res8, co8, qr8, qc8, qv8, sat8;
    logic [7:0] acc8, cnt8;
    logic       res4, co4, qr4, qc4, qv4, sat4;
    logic [3:0] acc4, cnt4;
    logic       res2, co2, qr2, qc2, qv2, sat2;
    logic [1:0] acc2, cnt2;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    int   m_acc[3];
    int   m_cnt[3];
    int   m_sat[3];
    int   m_qv;
    int   widths[3] = '{8, 4, 2};

    adder #(.ACC_W(8)) u8 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .in_valid(in_valid),
        .result(res8), .carry_out(co8), .q_result(qr8), .q_carry(qc8), .q_valid(qv8),
        .acc(acc8), .acc_sat(sat8), .sample_cnt(cnt8));
    adder #(.ACC_W(4)) u4 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .in_valid(in_valid),
        .result(res4), .carry_out(co4), .q_result(qr4), .q_carry(qc4), .q_valid(qv4),
        .acc(acc4), .acc_sat(sat4), .sample_cnt(cnt4));
    adder #(.ACC_W(2)) u2 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .in_valid(in_valid),
        .result(res2), .carry_out(co2), .q_result(qr2), .q_carry(qc2), .q_valid(qv2),
        .acc(acc2), .acc_sat(sat2), .sample_cnt(cnt2));

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_comb();
        int s;
        s = int'(a) + int'(b) + int'(c);
        chk("comb8", int'({co8, res8}), s);
        chk("comb4", int'({co4, res4}), s);
        chk("comb2", int'({co2, res2}), s);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0;
            m_cnt[k] = 0;
            m_sat[k] = 0;
        end
        m_qv = 0;
        sb_q.delete();
    endtask

    // One clock: drive on the low phase, update the model at the edge, check 1 ns later.
    task automatic step(input logic ia, input logic ib, input logic ic, input logic iv, input logic ir);
        int   s, mx;
        exp_t e;
        exp_t got_e;
        @(negedge clk);
        a = ia; b = ib; c = ic; in_valid = iv; rst = ir;
        @(posedge clk);
        s = int'(ia) + int'(ib) + int'(ic);
        if (ir) begin
            model_reset();
        end else if (iv) begin
            e.r = logic'(s & 1);
            e.c = logic'(s >> 1);
            sb_q.push_back(e);
            m_qv = 1;
            for (int k = 0; k < 3; k++) begin
                mx = (1 << widths[k]) - 1;
                if (m_acc[k] + s > mx) begin
                    m_acc[k] = mx;
                    m_sat[k] = 1;
                end else begin
                    m_acc[k] = m_acc[k] + s;
                end
                m_cnt[k] = (m_cnt[k] + 1) & mx;
            end
        end else begin
            m_qv = 0;
        end
        #1;
        chk_comb();
        chk("qv8", int'(qv8), m_qv);
        chk("qv4", int'(qv4), m_qv);
        chk("qv2", int'(qv2), m_qv);
        if (qv8 === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                got_e = sb_q.pop_front();
                chk("qres8", int'(qr8), int'(got_e.r));
                chk("qcar8", int'(qc8), int'(got_e.c));
                chk("qres4", int'(qr4), int'(got_e.r));
                chk("qcar4", int'(qc4), int'(got_e.c));
                chk("qres2", int'(qr2), int'(got_e.r));
                chk("qcar2", int'(qc2), int'(got_e.c));
            end
        end
        chk("acc8", int'(acc8), m_acc[0]);
        chk("acc4", int'(acc4), m_acc[1]);
        chk("acc2", int'(acc2), m_acc[2]);
        chk("sat8", int'(sat8), m_sat[0]);
        chk("sat4", int'(sat4), m_sat[1]);
        chk("sat2", int'(sat2), m_sat[2]);
        chk("cnt8", int'(cnt8), m_cnt[0]);
        chk("cnt4", int'(cnt4), m_cnt[1]);
        chk("cnt2", int'(cnt2), m_cnt[2]);
    endtask

    initial begin
        logic [2:0] v;
        model_reset();

        // Combinational core with clock idle, rst at both levels.
        for (int r = 0; r < 2; r++) begin
            rst = logic'(r);
            for (int i = 0; i < 8; i++) begin
                v = 3'(i);
                {c, b, a} = v;
                #10;
                chk_comb();
            end
        end

        clk_en = 1'b1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_acc8", int'(acc8), 0);
        chk("rst_qv8", int'(qv8), 0);

        // Registered latency: 1+1+0.
        step(1, 1, 0, 1, 0);
        chk("lat_qc", int'(qc8), 1);
        chk("lat_qr", int'(qr8), 0);
        chk("lat_acc", int'(acc8), 2);
        chk("lat_cnt", int'(cnt8), 1);
        step(0, 0, 0, 0, 0);
        chk("lat_qv_drop", int'(qv8), 0);

        // All eight combinations back-to-back.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            step(v[0], v[1], v[2], 1, 0);
        end
        chk("accum_acc", int'(acc8), 12);
        chk("accum_cnt", int'(cnt8), 8);
        chk("accum_sat", int'(sat8), 0);

        // Saturation on the 4-bit instance.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 1, 1, 0);
            if (i == 4) begin
                chk("sat5_acc4", int'(acc4), 15);
                chk("sat5_flag4", int'(sat4), 0);
            end
        end
        chk("sat6_acc4", int'(acc4), 15);
        chk("sat6_flag4", int'(sat4), 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("sat_sticky4", int'(sat4), 1);

        // Reset wins over a valid sample on the same edge.
        step(1, 1, 1, 1, 1);
        chk("rp_res", int'(res8), 1);
        chk("rp_co", int'(co8), 1);
        chk("rp_qv", int'(qv8), 0);
        chk("rp_acc4", int'(acc4), 0);
        chk("rp_sat4", int'(sat4), 0);

        // Sample counter wrap on the 2-bit instance.
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 0);
            chk("wrap_cnt2", int'(cnt2), (i + 1) % 4);
            chk("wrap_acc2", int'(acc2), 0);
            chk("wrap_sat2", int'(sat2), 0);
        end

        // Random traffic with occasional mid-stream reset.
        for (int i = 0; i < 60; i++) begin
            step(logic'($urandom_range(1)), logic'($urandom_range(1)), logic'($urandom_range(1)),
                 logic'($urandom_range(3) != 0), logic'($urandom_range(19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/adder.md
# adder

Single-bit full adder with a registered observation stage. The combinational core sums three 1-bit operands into a 2-bit value {carry_out, result}. A clocked side-path captures qualified samples and keeps a running total of all sums, for datapath self-checking and bring-up statistics. The block is a leaf cell used by ripple structures and by verification monitors.

## Interface
- ACC_W, default 8: width of the running-sum accumulator (minimum 2).
- clk  input  1  rising-edge clock for all registered outputs.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- a  input  1  operand bit 0.
- b  input  1  operand bit 1.
- c  input  1  operand bit 2 (carry-in).
- in_valid  input  1  qualifies a, b and c for the registered path.
- result  output  1  combinational sum bit, a XOR b XOR c.
- carry_out  output  1  combinational carry, majority(a, b, c).
- q_result  output  1  registered result.
- q_carry  output  1  registered carry_out.
- q_valid  output  1  high for one cycle after each accepted sample.
- acc  output  ACC_W  saturating running total of {carry_out, result} over accepted samples.
- acc_sat  output  1  sticky flag: the accumulator has saturated.
- sample_cnt  output  ACC_W  count of accepted samples, wraps modulo 2^ACC_W.

## Operation
- Arithmetic: {carry_out, result} = a + b + c, a 2-bit unsigned value in the range 0..3.
- Truth table by {c,b,a}: 000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11.
- result and carry_out are purely combinational. They do not depend on clk, rst or in_valid, and they stay correct while rst is asserted.
- A sample is accepted on a rising clk edge where rst=0 and in_valid=1.
- On acceptance:
  - q_result and q_carry load the current core outputs.
  - q_valid is set to 1.
  - sample_cnt increments by 1.
  - acc += {carry_out, result}, zero-extended to ACC_W.
- Saturation:
  - If the acc sum would exceed 2^ACC_W-1, acc is clamped to 2^ACC_W-1 and acc_sat is set.
  - acc_sat stays set until rst.
  - If acc is already at its maximum, adding 0 leaves acc_sat unchanged.
- On an edge with in_valid=0: q_valid is cleared to 0. q_result, q_carry, acc and sample_cnt hold their values.
- sample_cnt wraps from 2^ACC_W-1 to 0 without any flag.
- Reset values of all registered outputs: q_result=0, q_carry=0, q_valid=0, acc=0, acc_sat=0, sample_cnt=0.
- rst takes priority over in_valid on the same edge. The sample on that edge is discarded.
- Inputs X or Z are not supported and give undefined results.

## Timing
- Combinational path: result and carry_out settle within one propagation delay of any change on a, b or c. There is zero clock latency.
- Registered path: latency is 1 cycle. A sample accepted at edge N appears on q_result, q_carry and q_valid after edge N. acc and sample_cnt reflect that sample after the same edge N.
- Throughput is one sample per cycle. Back-to-back in_valid is fully supported with no stalls.
- Reset:
  - Synchronous; it takes effect only on a rising clk edge.
  - Asserting rst mid-stream clears all registered state on that edge.
  - The first sample after release is accepted on the first edge where rst=0.
- No handshake back-pressure: the block always accepts a sample.

## Test plan
- Exhaustive combinational check: drive {c,b,a} from 0 to 7, waiting 10 ns per step. Required: {carry_out,result} equals a+b+c at every step (0 gives 00; 3, 5 and 6 give 10; 7 gives 11), with clk idle and rst at either level.
- Registered latency: with rst released, apply a=1, b=1, c=0, in_valid=1 for one cycle. After that edge: q_carry=1, q_result=0, q_valid=1, acc=2, sample_cnt=1. On the next edge with in_valid=0, q_valid returns to 0.
- Accumulation: apply all 8 combinations back-to-back with in_valid=1. Required: acc=12, sample_cnt=8, acc_sat=0.
- Saturation with ACC_W=4: feed {c,b,a}=111 for 6 cycles. Required: acc reaches 15 on the 5th sample (sum 15); the 6th sample holds acc at 15 and sets acc_sat=1, which stays set.
- Reset priority: assert rst on the same edge as a valid sample of 111. Required: every registered output is 0 after that edge, while result and carry_out remain 1.
- Counter wrap with ACC_W=2: accept 4 samples of 000. Required: sample_cnt sequence 1, 2, 3, 0; acc stays 0; acc_sat stays 0.
